// File: rtl/ltssm_sequencer.sv
// Top-level LTSSM sequencer: owns the substate shared by the Rx and Tx LTSSM halves,
// captures negotiated link parameters and guards each substate with a watchdog.
module ltssm_sequencer #(
    parameter logic [7:0]  LINK_NUMBER_INIT = 8'hF7,
    parameter int unsigned TIMER_WIDTH      = 24,
    parameter int unsigned TIMEOUT_CYCLES   = 6000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxFinish,
    input  logic [3:0] rxExitTo,
    input  logic       txFinish,
    input  logic [3:0] txExitTo,
    input  logic       detectValid,
    input  logic [4:0] detectedLanes,
    input  logic       rxWriteRateId,
    input  logic [7:0] rxRateId,
    input  logic       rxUpconfig,
    input  logic       rxWriteLinkNumber,
    input  logic [7:0] rxLinkNumber,
    input  logic       lpifRetrain,
    output logic [3:0] substate,
    output logic       substateStart,
    output logic [4:0] numberOfDetectedLanes,
    output logic [7:0] linkNumber,
    output logic [7:0] rateId,
    output logic       upConfigureCapability,
    output logic       linkUp,
    output logic       seqError
);

    localparam logic [3:0] DET_QUIET     = 4'd0;
    localparam logic [3:0] DET_ACTIVE    = 4'd1;
    localparam logic [3:0] L0            = 4'd10;
    localparam logic [3:0] REC_RCVR_LOCK = 4'd11;

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    logic                   rxDone;
    logic                   txDone;
    logic [3:0]             rxExitQ;
    logic [3:0]             txExitQ;
    logic [TIMER_WIDTH-1:0] wdCount;

    logic       rxFinishEff;
    logic       txFinishEff;
    logic       rxHave;
    logic       txHave;
    logic [3:0] rxVal;
    logic [3:0] txVal;
    logic       wdActive;
    logic       wdExpired;
    logic       advance;
    logic       errNext;
    logic [3:0] nextState;

    // Finishes in the first cycle of a substate, or repeats from a side already done, are dropped.
    assign rxFinishEff = rxFinish & ~rxDone & ~substateStart;
    assign txFinishEff = txFinish & ~txDone & ~substateStart;
    assign rxHave      = rxDone | rxFinishEff;
    assign txHave      = txDone | txFinishEff;
    assign rxVal       = rxDone ? rxExitQ : rxExitTo;
    assign txVal       = txDone ? txExitQ : txExitTo;
    assign wdActive    = (substate != DET_QUIET) && (substate != L0);
    assign wdExpired   = wdActive && (wdCount == TIMEOUT_LAST);

    // Priority: both sides done, single-side fallback to DetQuiet, retrain, then watchdog.
    always_comb begin
        advance   = 1'b0;
        errNext   = 1'b0;
        nextState = substate;
        if (rxHave && txHave) begin
            advance   = 1'b1;
            nextState = rxVal;
            errNext   = (rxVal != txVal);
        end else if ((rxFinishEff && rxExitTo == DET_QUIET) ||
                     (txFinishEff && txExitTo == DET_QUIET)) begin
            advance   = 1'b1;
            nextState = DET_QUIET;
        end else if (substate == L0 && lpifRetrain) begin
            advance   = 1'b1;
            nextState = REC_RCVR_LOCK;
        end else if (wdExpired) begin
            advance   = 1'b1;
            nextState = DET_QUIET;
            errNext   = 1'b1;
        end
        if (advance && nextState > REC_RCVR_LOCK) begin
            nextState = DET_QUIET;
            errNext   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            substate      <= DET_QUIET;
            substateStart <= 1'b0;
            linkUp        <= 1'b0;
            seqError      <= 1'b0;
            rxDone        <= 1'b0;
            txDone        <= 1'b0;
            rxExitQ       <= 4'd0;
            txExitQ       <= 4'd0;
            wdCount       <= '0;
        end else begin
            substateStart <= advance;
            seqError      <= errNext;
            if (advance) begin
                substate <= nextState;
                linkUp   <= (nextState == L0);
                rxDone   <= 1'b0;
                txDone   <= 1'b0;
                wdCount  <= '0;
            end else begin
                if (rxFinishEff) begin
                    rxDone  <= 1'b1;
                    rxExitQ <= rxExitTo;
                end
                if (txFinishEff) begin
                    txDone  <= 1'b1;
                    txExitQ <= txExitTo;
                end
                wdCount <= wdActive ? wdCount + 1'b1 : '0;
            end
        end
    end

    // Returning to DetQuiet discards negotiated parameters, even against a same-cycle capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            numberOfDetectedLanes <= 5'd0;
            linkNumber            <= LINK_NUMBER_INIT;
            rateId                <= 8'd0;
            upConfigureCapability <= 1'b0;
        end else if (advance && nextState == DET_QUIET) begin
            numberOfDetectedLanes <= 5'd0;
            linkNumber            <= LINK_NUMBER_INIT;
            rateId                <= 8'd0;
            upConfigureCapability <= 1'b0;
        end else begin
            if (detectValid && substate == DET_ACTIVE) begin
                numberOfDetectedLanes <= detectedLanes;
            end
            if (rxWriteRateId) begin
                rateId                <= rxRateId;
                upConfigureCapability <= rxUpconfig;
            end
            if (rxWriteLinkNumber) begin
                linkNumber <= rxLinkNumber;
            end
        end
    end

endmodule
